mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: read-only fetch port and load/store port share one
// registered single-port memory through a three-state IDLE/ACCESS/RESP sequencer.
module mem_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0] state_q;
    logic       win_q;   // port owning the current access (1 = port 1)
    logic       last_q;  // port granted most recently (1 = port 1)
    logic       pick_p1;

    // Port 1 wins when alone, or on a tie when port 0 was granted last.
    always_comb begin
        pick_p1 = p1_req && (!p0_req || !last_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            case (state_q)
                IDLE: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    if (p0_req || p1_req) begin
                        state_q <= ACCESS;
                        busy    <= 1'b1;
                        win_q   <= pick_p1;
                        last_q  <= pick_p1;
                        if (pick_p1) begin
                            mem_addr  <= p1_addr;
                            mem_wdata <= p1_wdata;
                            mem_we    <= p1_we;
                            mem_re    <= !p1_we;
                            p1_gnt    <= 1'b1;
                        end else begin
                            // Fetch port is read-only; mem_wdata keeps its last value.
                            mem_addr <= p0_addr;
                            mem_re   <= 1'b1;
                            p0_gnt   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    if (win_q) begin
                        p1_rdata  <= mem_rdata;
                        p1_rvalid <= 1'b1;
                    end else begin
                        p0_rdata  <= mem_rdata;
                        p0_rvalid <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    mem_re  <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered memory model and a
// grant/read-data scoreboard checked by an always-on monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_gnt, p0_rvalid;
    logic [7:0]  p0_addr;
    logic [15:0] p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [7:0]  p1_addr;
    logic [15:0] p1_wdata, p1_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;

    logic [15:0] mem [256];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [15:0] bd_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_re = 0, n_we = 0, n_rv0 = 0, n_rv1 = 0, n_g1 = 0;

    int          gnt_q[$];
    logic [15:0] rd0_q[$];
    logic [15:0] rd1_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Registered single-port memory with a backdoor preload path
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_we) mem[bd_addr] <= bd_data;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (mem_re || mem_we) chk("mem_excl", 32'(mem_re & mem_we), 32'd0);
        if (p0_gnt || p1_gnt) begin
            chk("gnt_excl", 32'(p0_gnt & p1_gnt), 32'd0);
            chk("gnt_expected", 32'(gnt_q.size() != 0), 32'd1);
            if (gnt_q.size() != 0) chk("gnt_port", 32'(p1_gnt), 32'(gnt_q.pop_front()));
        end
        if (p0_rvalid || p1_rvalid) chk("rv_excl", 32'(p0_rvalid & p1_rvalid), 32'd0);
        if (p0_rvalid) begin
            chk("p0_rv_expected", 32'(rd0_q.size() != 0), 32'd1);
            if (rd0_q.size() != 0) chk("p0_rdata", 32'(p0_rdata), 32'(rd0_q.pop_front()));
        end
        if (p1_rvalid) begin
            chk("p1_rv_expected", 32'(rd1_q.size() != 0), 32'd1);
            if (rd1_q.size() != 0) chk("p1_rdata", 32'(p1_rdata), 32'(rd1_q.pop_front()));
        end
        if (mem_re) n_re++;
        if (mem_we) n_we++;
        if (p0_rvalid) n_rv0++;
        if (p1_rvalid) n_rv1++;
        if (p1_gnt) n_g1++;
    end

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Returns at the negedge where the requested port's grant is seen
    task automatic wait_gnt(input logic port, output int t);
        logic seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? p1_gnt : p0_gnt) begin
                seen = 1'b1;
                break;
            end
        end
        t = cyc;
        chk(port ? "p1_gnt_seen" : "p0_gnt_seen", 32'(seen), 32'd1);
    endtask

    task automatic p1_op(input logic we, input logic [7:0] a, input logic [15:0] d);
        int t;
        p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = we ? d : 16'h0;
        gnt_q.push_back(1);
        if (!we) rd1_q.push_back(d);
        wait_gnt(1'b1, t);
        p1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int t0, t1, g;
        rst_n = 1'b0; p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        preload(8'h10, 16'hBEEF);
        preload(8'h30, 16'hCAFE);
        preload(8'h31, 16'h0F0F);

        // Reset state
        @(negedge clk);
        chk("reset_ctl", 32'({busy, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_re, mem_we}), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", 32'(mem_wdata), 32'd0);
        chk("reset_rdata", {p0_rdata, p1_rdata}, 32'd0);

        // Single fetch read: gnt/mem_re in cycle 1, rvalid in cycle 3
        rst_n = 1'b1; p0_req = 1'b1; p0_addr = 8'h10;
        gnt_q.push_back(0); rd0_q.push_back(16'hBEEF);
        n_re = 0;
        @(negedge clk);
        chk("rd_c1_gnt", 32'(p0_gnt), 32'd1);
        chk("rd_c1_re", 32'({mem_re, mem_we, busy}), 32'b101);
        chk("rd_c1_addr", 32'(mem_addr), 32'h10);
        p0_req = 1'b0;
        @(negedge clk);
        chk("rd_c2", 32'({p0_gnt, mem_re, p0_rvalid}), 32'd0);
        @(negedge clk);
        chk("rd_c3_rvalid", 32'({p0_rvalid, busy}), 32'b10);
        chk("rd_c3_rdata", 32'(p0_rdata), 32'hBEEF);
        @(negedge clk);
        chk("rd_c4_hold", 32'({p0_rvalid, p0_rdata}), 32'h0BEEF);
        chk("rd_re_count", 32'(n_re), 32'd1);

        // Store then load back on port 1
        n_we = 0; n_rv1 = 0;
        p1_op(1'b1, 8'h20, 16'h1234);
        chk("wr_issue", 32'({mem_we, mem_re}), 32'b10);
        chk("wr_payload", {8'h0, mem_addr, mem_wdata}, 32'h00201234);
        @(negedge clk);
        chk("wr_done", 32'({mem_we, busy}), 32'd0);
        @(negedge clk);
        chk("wr_we_count", 32'(n_we), 32'd1);
        chk("wr_no_rvalid", 32'(n_rv1), 32'd0);
        chk("wr_wdata_hold", 32'(mem_wdata), 32'h1234);
        p1_op(1'b0, 8'h20, 16'h1234);
        repeat (3) @(negedge clk);
        chk("rb_rvalid_count", 32'(n_rv1), 32'd1);
        chk("rb_rdata", 32'(p1_rdata), 32'h1234);

        // Both ports requesting continuously from reset: p0,p1,p0,p1
        rst_n = 1'b0;
        p0_req = 1'b1; p0_addr = 8'h30;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h31;
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
        rd0_q.push_back(16'hCAFE); rd0_q.push_back(16'hCAFE);
        rd1_q.push_back(16'h0F0F); rd1_q.push_back(16'h0F0F);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        g = 0;
        for (int i = 0; i < 40 && g < 4; i++) begin
            @(negedge clk);
            if (p0_gnt || p1_gnt) g++;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("rr_grants", 32'(g), 32'd4);
        repeat (3) @(negedge clk);
        chk("rr_gnt_drained", 32'(gnt_q.size()), 32'd0);
        chk("rr_rd_drained", 32'(rd0_q.size() + rd1_q.size()), 32'd0);

        // Port 1 pulse while busy must be ignored
        p0_req = 1'b1; p0_addr = 8'h10;
        gnt_q.push_back(0); rd0_q.push_back(16'hBEEF);
        wait_gnt(1'b0, t0);
        p0_req = 1'b0;
        n_we = 0; n_g1 = 0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h40; p1_wdata = 16'hDEAD;
        @(negedge clk);
        p1_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("pulse_no_gnt", 32'(n_g1), 32'd0);
        chk("pulse_no_we", 32'(n_we), 32'd0);

        // Reset during the ACCESS cycle of a read abandons it
        p0_req = 1'b1; p0_addr = 8'h10;
        gnt_q.push_back(0);
        wait_gnt(1'b0, t0);
        p0_req = 1'b0; rst_n = 1'b0; n_rv0 = 0;
        @(negedge clk);
        chk("rst_mid_busy", 32'({busy, mem_re, p0_gnt}), 32'd0);
        chk("rst_mid_rdata", 32'(p0_rdata), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_rvalid", 32'(n_rv0), 32'd0);
        p1_op(1'b0, 8'h20, 16'h1234);
        repeat (3) @(negedge clk);
        chk("rst_mid_next_ok", 32'(p1_rdata), 32'h1234);

        // Back-to-back writes to the address extremes
        n_we = 0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h00; p1_wdata = 16'hA5A5;
        gnt_q.push_back(1); gnt_q.push_back(1);
        wait_gnt(1'b1, t0);
        p1_addr = 8'hFF; p1_wdata = 16'h5A5A;
        wait_gnt(1'b1, t1);
        p1_req = 1'b0;
        chk("b2b_spacing", 32'(t1 - t0), 32'd2);
        repeat (2) @(negedge clk);
        chk("b2b_we_count", 32'(n_we), 32'd2);
        chk("b2b_mem_lo", 32'(mem[8'h00]), 32'hA5A5);
        chk("b2b_mem_hi", 32'(mem[8'hFF]), 32'h5A5A);
        p1_op(1'b0, 8'h00, 16'hA5A5);
        repeat (3) @(negedge clk);
        p1_op(1'b0, 8'hFF, 16'h5A5A);
        repeat (3) @(negedge clk);
        chk("b2b_rb_hi", 32'(p1_rdata), 32'h5A5A);

        chk("end_gnt_q", 32'(gnt_q.size()), 32'd0);
        chk("end_rd_q", 32'(rd0_q.size() + rd1_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
